// File: rtl/wh_output_port.sv
// -----------------------------------------------------------------------------
// wh_output_port
//
// Router output-port controller, one instance per output port, sitting
// directly downstream of the round-robin arbiter. It presents head-flit
// requests to the arbiter, pulses the arbiter update strobe, captures the
// registered one-hot grant and then locks the winning input for a whole
// wormhole packet (head .. tail). Flits of the locked input are forwarded
// through a registered valid/ready output stage (1 cycle latency,
// 1 flit/cycle sustained).
//
// Flit type lives in bits [FLIT_WIDTH-1:FLIT_WIDTH-2]:
//    00 head, 01 body, 10 tail, 11 head+tail (single-flit packet)
//
// Ports:
//    clk           clock
//    arst_n        asynchronous active-low reset
//    in_valid_i    per-input flit valid
//    in_flit_i     per-input flit, input i at [i*FLIT_WIDTH +: FLIT_WIDTH]
//    in_ready_o    per-input ready (only the locked input can be ready)
//    arb_req_o     head-flit request vector to the arbiter
//    arb_update_o  arbiter update strobe (one cycle, from IDLE)
//    arb_grant_i   registered one-hot grant from the arbiter
//    out_valid_o   registered output valid
//    out_flit_o    registered output flit
//    out_ready_i   downstream ready
//    err_o         sticky protocol error
//
// Build option:
//    WH_OUT_CHECK_EN  when defined, err_o flags a head / head+tail flit
//                     transferred after the packet head while locked, and a
//                     non-one-hot grant in GRANT. When undefined, err_o is
//                     tied low and no check logic exists.
// -----------------------------------------------------------------------------
module wh_output_port #(
   parameter int N_OF_INPUTS = 4,
   parameter int FLIT_WIDTH  = 34
) (
   input  logic                              clk,
   input  logic                              arst_n,
   input  logic [N_OF_INPUTS-1:0]            in_valid_i,
   input  logic [N_OF_INPUTS*FLIT_WIDTH-1:0] in_flit_i,
   output logic [N_OF_INPUTS-1:0]            in_ready_o,
   output logic [N_OF_INPUTS-1:0]            arb_req_o,
   output logic                              arb_update_o,
   input  logic [N_OF_INPUTS-1:0]            arb_grant_i,
   output logic                              out_valid_o,
   output logic [FLIT_WIDTH-1:0]             out_flit_o,
   input  logic                              out_ready_i,
   output logic                              err_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   // Body (2'b01) needs no decode: it is neither a packet start nor an end.
   localparam logic [1:0] TYPE_HEAD = 2'b00;
   localparam logic [1:0] TYPE_TAIL = 2'b10;
   localparam logic [1:0] TYPE_HT   = 2'b11;

   function automatic logic is_head(input logic [1:0] t);
      return (t == TYPE_HEAD) || (t == TYPE_HT);
   endfunction

   function automatic logic is_tail(input logic [1:0] t);
      return (t == TYPE_TAIL) || (t == TYPE_HT);
   endfunction

   state_t                   state_q, state_d;
   logic [N_OF_INPUTS-1:0]   lock_q, lock_d;
   logic                     out_valid_q, out_valid_d;
   logic [FLIT_WIDTH-1:0]    out_flit_q, out_flit_d;

   logic [FLIT_WIDTH-1:0]    sel_flit_s;
   logic [1:0]               sel_type_s;
   logic                     xfer_s;
   logic                     out_free_s;

   // Head-flit requests: any valid head or head+tail flit asks for arbitration.
   always_comb begin
      arb_req_o = '0;
      for (int i = 0; i < N_OF_INPUTS; i++) begin
         arb_req_o[i] = in_valid_i[i] &&
                        is_head(in_flit_i[i*FLIT_WIDTH + FLIT_WIDTH - 2 +: 2]);
      end
   end

   // Output stage can accept a new flit when empty or being drained this cycle.
   assign out_free_s = !out_valid_q || out_ready_i;

   // Flit mux: AND-OR over the lock vector so no priority logic is needed.
   always_comb begin
      sel_flit_s = '0;
      for (int i = 0; i < N_OF_INPUTS; i++) begin
         sel_flit_s = sel_flit_s |
                      ({FLIT_WIDTH{lock_q[i]}} & in_flit_i[i*FLIT_WIDTH +: FLIT_WIDTH]);
      end
   end

   assign sel_type_s = sel_flit_s[FLIT_WIDTH-1 -: 2];
   assign xfer_s     = |(in_valid_i & in_ready_o);

   // State and lock vector register.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= ST_IDLE;
         lock_q  <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
      end
   end

   // Next-state logic; the lock vector only changes on leaving GRANT or on a tail.
   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      case (state_q)
         ST_IDLE: begin
            if (|arb_req_o) begin
               state_d = ST_GRANT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            // Zero grant means every request was withdrawn: re-arbitrate.
            if (|arb_grant_i) begin
               lock_d  = arb_grant_i;
               state_d = ST_LOCKED;
            end else begin
               lock_d  = '0;
               state_d = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            if (xfer_s && is_tail(sel_type_s)) begin
               lock_d  = '0;
               state_d = ST_IDLE;
            end else begin
               lock_d  = lock_q;
               state_d = ST_LOCKED;
            end
         end
         default: begin
            lock_d  = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: update strobe from IDLE, readiness only for the locked input.
   always_comb begin
      arb_update_o = 1'b0;
      in_ready_o   = '0;
      case (state_q)
         ST_IDLE: begin
            arb_update_o = |arb_req_o;
            in_ready_o   = '0;
         end
         ST_GRANT: begin
            arb_update_o = 1'b0;
            in_ready_o   = '0;
         end
         ST_LOCKED: begin
            arb_update_o = 1'b0;
            in_ready_o   = lock_q & {N_OF_INPUTS{out_free_s}};
         end
         default: begin
            arb_update_o = 1'b0;
            in_ready_o   = '0;
         end
      endcase
   end

   // Output register next values: load on transfer, drop valid once drained.
   always_comb begin
      out_valid_d = out_valid_q;
      out_flit_d  = out_flit_q;
      if (xfer_s) begin
         out_valid_d = 1'b1;
         out_flit_d  = sel_flit_s;
      end else if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
         out_flit_d  = out_flit_q;
      end else begin
         out_valid_d = out_valid_q;
         out_flit_d  = out_flit_q;
      end
   end

   // Output register.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         out_valid_q <= 1'b0;
         out_flit_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_flit_q  <= out_flit_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_flit_o  = out_flit_q;

`ifdef WH_OUT_CHECK_EN
   logic head_seen_q, head_seen_d;
   logic err_q, err_d;

   function automatic logic is_onehot(input logic [N_OF_INPUTS-1:0] g);
      return (g != '0) &&
             ((g & (g - {{(N_OF_INPUTS-1){1'b0}}, 1'b1})) == '0);
   endfunction

   // Protocol checks; head_seen marks that the packet head already went out,
   // so a later head-type flit in the same lock is a framing error.
   always_comb begin
      head_seen_d = head_seen_q;
      err_d       = err_q;
      if (state_q == ST_LOCKED) begin
         if (xfer_s) begin
            if (head_seen_q && is_head(sel_type_s)) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
            if (is_tail(sel_type_s)) begin
               head_seen_d = 1'b0;
            end else begin
               head_seen_d = 1'b1;
            end
         end else begin
            head_seen_d = head_seen_q;
         end
      end else if (state_q == ST_GRANT) begin
         head_seen_d = 1'b0;
         if ((|arb_grant_i) && !is_onehot(arb_grant_i)) begin
            err_d = 1'b1;
         end else begin
            err_d = err_q;
         end
      end else begin
         head_seen_d = 1'b0;
      end
   end

   // Sticky error and head tracking registers.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         head_seen_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         head_seen_q <= head_seen_d;
         err_q       <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule
